// File: rtl/edge_window_scheduler_if.sv
// Bus bundle for edge_window_scheduler: synchronized video timing in, line-buffer/window control out.
// O_ERR exists only when EDGE_SCHED_ERR_EN is defined.
interface edge_window_scheduler_if #(
    parameter int COL_W = 10,
    parameter int ROW_W = 10
);
    logic             I_VSYNC;
    logic             I_DE;
    logic             I_PIX_STB;
    logic             O_LB_WR_EN;
    logic [COL_W-1:0] O_LB_ADDR;
    logic [1:0]       O_WR_BANK;
    logic             O_WIN_VALID;
    logic [ROW_W-1:0] O_CTR_ROW;
    logic [COL_W-1:0] O_CTR_COL;
    logic             O_FRAME_DONE;
`ifdef EDGE_SCHED_ERR_EN
    logic             O_ERR;

    modport master (
        output I_VSYNC, I_DE, I_PIX_STB,
        input  O_LB_WR_EN, O_LB_ADDR, O_WR_BANK, O_WIN_VALID,
               O_CTR_ROW, O_CTR_COL, O_FRAME_DONE, O_ERR
    );
    modport slave (
        input  I_VSYNC, I_DE, I_PIX_STB,
        output O_LB_WR_EN, O_LB_ADDR, O_WR_BANK, O_WIN_VALID,
               O_CTR_ROW, O_CTR_COL, O_FRAME_DONE, O_ERR
    );
`else
    modport master (
        output I_VSYNC, I_DE, I_PIX_STB,
        input  O_LB_WR_EN, O_LB_ADDR, O_WR_BANK, O_WIN_VALID,
               O_CTR_ROW, O_CTR_COL, O_FRAME_DONE
    );
    modport slave (
        input  I_VSYNC, I_DE, I_PIX_STB,
        output O_LB_WR_EN, O_LB_ADDR, O_WR_BANK, O_WIN_VALID,
               O_CTR_ROW, O_CTR_COL, O_FRAME_DONE
    );
`endif
endinterface

// File: rtl/edge_window_scheduler.sv
// Sequences the 3-line-buffer Sobel window: row/column tracking, bank rotation, 3x3 window flag.
// Optional EDGE_SCHED_ERR_EN adds a sticky line-width / overflow error flag (O_ERR).
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | after reset; waits for the first VSYNC rising edge
// S_WAIT_LINE | inside a frame, between lines; waits for DE high
// S_LINE      | active line; accepts pixel strobes until DE falls
module edge_window_scheduler #(
    parameter int MAX_WIDTH = 1024,
    parameter int COL_W     = 10,
    parameter int ROW_W     = 10
) (
    input  logic                     I_CORE_CLK,
    input  logic                     I_RST,
    edge_window_scheduler_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_LINE = 2'd1,
        S_LINE      = 2'd2
    } state_t;

    // Column counter carries one extra bit so it can reach MAX_WIDTH == 2^COL_W.
    localparam logic [COL_W:0] MAX_COL = MAX_WIDTH[COL_W:0];

    state_t           state_q, state_d;
    logic             vs_q, de_q;
    logic [COL_W:0]   col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [1:0]       bank_q, bank_d;
    logic             wr_en_q, wr_en_d;
    logic [COL_W-1:0] addr_q, addr_d;
    logic             win_q, win_d;
    logic [ROW_W-1:0] ctr_row_q, ctr_row_d;
    logic [COL_W-1:0] ctr_col_q, ctr_col_d;
    logic             done_q, done_d;

    logic vs_rise, de_fall, pix_req, accept, overflow;

    assign vs_rise  = bus.I_VSYNC & ~vs_q;
    assign de_fall  = ~bus.I_DE & de_q;
    assign pix_req  = (state_q == S_LINE) & bus.I_PIX_STB & bus.I_DE & ~vs_rise;
    assign accept   = pix_req & (col_q < MAX_COL);
    assign overflow = pix_req & (col_q >= MAX_COL);

    always_ff @(posedge I_CORE_CLK or negedge I_RST) begin
        if (!I_RST) begin
            state_q   <= S_IDLE;
            vs_q      <= 1'b0;
            de_q      <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
            bank_q    <= '0;
            wr_en_q   <= 1'b0;
            addr_q    <= '0;
            win_q     <= 1'b0;
            ctr_row_q <= '0;
            ctr_col_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            vs_q      <= bus.I_VSYNC;
            de_q      <= bus.I_DE;
            col_q     <= col_d;
            row_q     <= row_d;
            bank_q    <= bank_d;
            wr_en_q   <= wr_en_d;
            addr_q    <= addr_d;
            win_q     <= win_d;
            ctr_row_q <= ctr_row_d;
            ctr_col_q <= ctr_col_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        bank_d    = bank_q;
        wr_en_d   = 1'b0;
        addr_d    = addr_q;
        win_d     = 1'b0;
        ctr_row_d = ctr_row_q;
        ctr_col_d = ctr_col_q;
        done_d    = 1'b0;

        // A frame sync outranks everything else in the cycle, including a pixel strobe.
        if (vs_rise) begin
            done_d  = (state_q != S_IDLE) && (row_q != '0);
            state_d = S_WAIT_LINE;
            col_d   = '0;
            row_d   = '0;
            bank_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_WAIT_LINE: begin
                    if (bus.I_DE) begin
                        state_d = S_LINE;
                    end
                end
                S_LINE: begin
                    if (de_fall) begin
                        state_d = S_WAIT_LINE;
                        col_d   = '0;
                        if (row_q != '1) begin
                            row_d = row_q + ROW_W'(1);
                        end
                        bank_d = (bank_q == 2'd2) ? 2'd0 : bank_q + 2'd1;
                    end else if (accept) begin
                        wr_en_d = 1'b1;
                        addr_d  = col_q[COL_W-1:0];
                        col_d   = col_q + (COL_W+1)'(1);
                        if ((row_q >= ROW_W'(2)) && (col_q >= (COL_W+1)'(2))) begin
                            win_d     = 1'b1;
                            ctr_row_d = row_q - ROW_W'(1);
                            ctr_col_d = col_q[COL_W-1:0] - COL_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign bus.O_LB_WR_EN   = wr_en_q;
    assign bus.O_LB_ADDR    = addr_q;
    assign bus.O_WR_BANK    = bank_q;
    assign bus.O_WIN_VALID  = win_q;
    assign bus.O_CTR_ROW    = ctr_row_q;
    assign bus.O_CTR_COL    = ctr_col_q;
    assign bus.O_FRAME_DONE = done_q;

`ifdef EDGE_SCHED_ERR_EN
    logic           err_q, err_d;
    logic [COL_W:0] width_q, width_d;

    always_ff @(posedge I_CORE_CLK or negedge I_RST) begin
        if (!I_RST) begin
            err_q   <= 1'b0;
            width_q <= '0;
        end else begin
            err_q   <= err_d;
            width_q <= width_d;
        end
    end

    // Row 0 defines the reference width; every later line must match it.
    always_comb begin
        err_d   = err_q;
        width_d = width_q;
        if (vs_rise) begin
            err_d = 1'b0;
        end else begin
            if (overflow) begin
                err_d = 1'b1;
            end
            if ((state_q == S_LINE) && de_fall) begin
                if (row_q == '0) begin
                    width_d = col_q;
                end else if (col_q != width_q) begin
                    err_d = 1'b1;
                end
            end
        end
    end

    assign bus.O_ERR = err_q;
`endif

endmodule

// File: tb/tb_edge_window_scheduler.sv
// Randomized + directed bench for edge_window_scheduler against a frame/line/pixel reference model.
module tb_edge_window_scheduler;
    localparam int MW   = 8;
    localparam int CW   = 3;
    localparam int RW   = 3;
    localparam int RMAX = (1 << RW) - 1;

    logic clk_sys = 1'b0;
    logic rst_b   = 1'b0;
    always #5 clk_sys = ~clk_sys;

    edge_window_scheduler_if #(.COL_W(CW), .ROW_W(RW)) bus ();

    edge_window_scheduler #(.MAX_WIDTH(MW), .COL_W(CW), .ROW_W(RW)) dut (
        .I_CORE_CLK (clk_sys),
        .I_RST      (rst_b),
        .bus        (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: frame/line flags plus position counters
    bit m_frame, m_line, m_vs, m_de, m_err;
    int m_row, m_col, m_bank, m_width;
    bit e_we, e_wv, e_fd;
    int e_addr, e_crow, e_ccol;

    int wr_log[$];
    int bank_log[$];
    int wrow_log[$];
    int wcol_log[$];
    int fd_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_frame = 0; m_line = 0; m_vs = 0; m_de = 0; m_err = 0;
        m_row = 0; m_col = 0; m_bank = 0; m_width = 0;
        e_we = 0; e_wv = 0; e_fd = 0; e_addr = 0; e_crow = 0; e_ccol = 0;
    endtask

    task automatic clear_logs();
        wr_log.delete(); bank_log.delete(); wrow_log.delete(); wcol_log.delete();
        fd_cnt = 0;
    endtask

    // Predict from the inputs present before the edge, then compare 1 ns after it.
    task automatic step();
        bit vr, df;
        vr = bus.I_VSYNC & ~m_vs;
        df = ~bus.I_DE & m_de;
        e_we = 0; e_wv = 0; e_fd = 0;
        if (vr) begin
            e_fd = m_frame && (m_row > 0);
            m_frame = 1; m_line = 0;
            m_row = 0; m_col = 0; m_bank = 0; m_err = 0;
        end else if (m_frame && !m_line) begin
            if (bus.I_DE) m_line = 1;
        end else if (m_frame && df) begin
            if (m_row == 0) m_width = m_col;
            else if (m_col != m_width) m_err = 1;
            m_col  = 0;
            m_row  = (m_row == RMAX) ? RMAX : m_row + 1;
            m_bank = (m_bank + 1) % 3;
            m_line = 0;
        end else if (m_frame && bus.I_PIX_STB && bus.I_DE) begin
            if (m_col < MW) begin
                e_we = 1; e_addr = m_col;
                if (m_row >= 2 && m_col >= 2) begin
                    e_wv = 1; e_crow = m_row - 1; e_ccol = m_col - 1;
                end
                m_col++;
            end else begin
                m_err = 1;
            end
        end
        m_vs = bus.I_VSYNC;
        m_de = bus.I_DE;
        @(posedge clk_sys);
        #1;
        chk("wr_en", bus.O_LB_WR_EN, e_we);
        if (e_we) chk("addr", bus.O_LB_ADDR, e_addr);
        chk("bank", bus.O_WR_BANK, m_bank);
        chk("win_valid", bus.O_WIN_VALID, e_wv);
        chk("ctr_row", bus.O_CTR_ROW, e_crow);
        chk("ctr_col", bus.O_CTR_COL, e_ccol);
        chk("frame_done", bus.O_FRAME_DONE, e_fd);
`ifdef EDGE_SCHED_ERR_EN
        chk("err", bus.O_ERR, m_err);
`endif
        if (bus.O_LB_WR_EN) begin
            wr_log.push_back(int'(bus.O_LB_ADDR));
            bank_log.push_back(int'(bus.O_WR_BANK));
        end
        if (bus.O_WIN_VALID) begin
            wrow_log.push_back(int'(bus.O_CTR_ROW));
            wcol_log.push_back(int'(bus.O_CTR_COL));
        end
        if (bus.O_FRAME_DONE) fd_cnt++;
    endtask

    task automatic drive(input logic vs, input logic de, input logic stb);
        bus.I_VSYNC   = vs;
        bus.I_DE      = de;
        bus.I_PIX_STB = stb;
        step();
    endtask

    task automatic vsync();
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic line(input int w, input int gap, input int vs_at);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < w; i++) begin
            drive(i == vs_at, 1'b1, 1'b1);
            for (int g = 1; g < gap; g++) drive(1'b0, 1'b1, 1'b0);
        end
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    endtask

    task automatic pulse_reset();
        #2;
        rst_b = 1'b0;
        #1;
        chk("rst_wr_en", bus.O_LB_WR_EN, 0);
        chk("rst_addr", bus.O_LB_ADDR, 0);
        chk("rst_bank", bus.O_WR_BANK, 0);
        chk("rst_win", bus.O_WIN_VALID, 0);
        chk("rst_ctr_row", bus.O_CTR_ROW, 0);
        chk("rst_ctr_col", bus.O_CTR_COL, 0);
        chk("rst_done", bus.O_FRAME_DONE, 0);
`ifdef EDGE_SCHED_ERR_EN
        chk("rst_err", bus.O_ERR, 0);
`endif
        model_reset();
        @(posedge clk_sys);
        #1;
        rst_b = 1'b1;
    endtask

    initial begin
        int exp_bank[4];
        int n;
        exp_bank = '{0, 1, 2, 0};
        bus.I_VSYNC = 1'b0; bus.I_DE = 1'b0; bus.I_PIX_STB = 1'b0;
        model_reset();
        clear_logs();
        @(posedge clk_sys);
        #1;
        pulse_reset();

        // 4 lines x 6 pixels, one strobe every 3 cycles
        vsync();
        for (int l = 0; l < 4; l++) line(6, 3, -1);
        chk("t1_wr_cnt", wr_log.size(), 24);
        n = (wr_log.size() < 24) ? wr_log.size() : 24;
        for (int i = 0; i < n; i++) chk("t1_addr_seq", wr_log[i], i % 6);
        for (int l = 0; l < 4; l++)
            if (l * 6 < bank_log.size()) chk("t1_bank_seq", bank_log[l * 6], exp_bank[l]);
        chk("t1_win_cnt", wrow_log.size(), 8);
        n = (wrow_log.size() < 8) ? wrow_log.size() : 8;
        for (int k = 0; k < n; k++) begin
            chk("t1_win_row", wrow_log[k], 1 + k / 4);
            chk("t1_win_col", wcol_log[k], 1 + k % 4);
        end

        // second vsync ends the frame
        clear_logs();
        vsync();
        chk("t2_frame_done_cnt", fd_cnt, 1);
        chk("t2_bank_zero", bus.O_WR_BANK, 0);
        line(1, 3, -1);
        chk("t2_first_addr_cnt", wr_log.size(), 1);
        if (wr_log.size() > 0) chk("t2_first_addr", wr_log[0], 0);

        // overflow: 10 strobes on one line
        clear_logs();
        line(10, 2, -1);
        chk("t3_wr_cnt", wr_log.size(), MW);
        n = (wr_log.size() < MW) ? wr_log.size() : MW;
        for (int i = 0; i < n; i++) chk("t3_addr_seq", wr_log[i], i);
`ifdef EDGE_SCHED_ERR_EN
        chk("t3_err_ovf", bus.O_ERR, 1);
`endif

        // vsync coincident with a strobe mid-line 3
        vsync();
        line(4, 1, -1);
        line(4, 1, -1);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1);
        clear_logs();
        drive(1'b1, 1'b1, 1'b1);
        chk("t4_drop_wr", bus.O_LB_WR_EN, 0);
        chk("t4_drop_win", bus.O_WIN_VALID, 0);
        chk("t4_bank", bus.O_WR_BANK, 0);
        chk("t4_done", fd_cnt, 1);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);

        // reset mid line 2, strobes ignored until next vsync
        line(6, 2, -1);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1);
        pulse_reset();
        clear_logs();
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        line(3, 1, -1);
        chk("t5_ignored", wr_log.size(), 0);
        vsync();
        line(3, 2, -1);
        chk("t5_restart_cnt", wr_log.size(), 3);
        if (wr_log.size() > 0) chk("t5_restart_addr", wr_log[0], 0);

        // widths 6,6,5
        vsync();
        line(6, 2, -1);
        line(6, 2, -1);
`ifdef EDGE_SCHED_ERR_EN
        chk("t6_err_before", bus.O_ERR, 0);
`endif
        line(5, 2, -1);
`ifdef EDGE_SCHED_ERR_EN
        chk("t6_err_after", bus.O_ERR, 1);
`endif
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0);
        vsync();
`ifdef EDGE_SCHED_ERR_EN
        chk("t6_err_cleared", bus.O_ERR, 0);
`endif

        // randomized frames
        for (int f = 0; f < 30; f++) begin
            int nl;
            vsync();
            nl = $urandom_range(0, 10);
            for (int l = 0; l < nl; l++) begin
                int w, vs_at;
                w = $urandom_range(0, 11);
                vs_at = ($urandom_range(0, 9) == 0 && w > 0) ? $urandom_range(0, w - 1) : -1;
                line(w, $urandom_range(1, 3), vs_at);
            end
            for (int i = 0; i < 2; i++)
                drive(1'b0, 1'b0, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 14) == 0) pulse_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/edge_window_scheduler.md
Name: edge_window_scheduler

Overview:
- Core-clock-domain controller that sequences the 3-line-buffer Sobel window datapath inside edge_detection_top.
- Consumes sync/DE/pixel-strobe already synchronized from the I_PCLK domain into I_CORE_CLK.
- Tracks row/column position and rotates line-buffer banks.
- Issues write enables and addresses, and flags when a full 3x3 window is available for the kernel.

Parameters:
- MAX_WIDTH, 1024, maximum active pixels per line.
- COL_W, 10, column counter / line-buffer address width; must satisfy 2^COL_W >= MAX_WIDTH.
- ROW_W, 10, row counter width; saturates at all-ones.

Ports:
- I_CORE_CLK  in  1  core clock; all logic on its rising edge.
- I_RST  in  1  asynchronous, active-low reset.
- I_VSYNC  in  1  frame sync, core-domain synchronized, active high.
- I_DE  in  1  data enable, core-domain synchronized, level.
- I_PIX_STB  in  1  one-cycle strobe per pixel delivered by CDC.
- O_LB_WR_EN  out  1  line-buffer write enable.
- O_LB_ADDR  out  COL_W  line-buffer write/read address (column).
- O_WR_BANK  out  2  bank being written (0..2); mid = (O_WR_BANK+2)%3; top = (O_WR_BANK+1)%3.
- O_WIN_VALID  out  1  3x3 window complete; center at (O_CTR_ROW, O_CTR_COL).
- O_CTR_ROW  out  ROW_W  window center row.
- O_CTR_COL  out  COL_W  window center column.
- O_FRAME_DONE  out  1  one-cycle pulse at frame end.

Behaviour:
- Reset (I_RST=0, asynchronous): every output 0; O_WR_BANK=0; col=0; row=0; state IDLE.
- Edge detection: registered previous values of I_VSYNC and I_DE. vs_rise = I_VSYNC & ~vs_q. de_fall = ~I_DE & de_q.
- States and transitions:
  - IDLE: on vs_rise -> WAIT_LINE; row=0, col=0, O_WR_BANK=0.
  - WAIT_LINE: when I_DE=1 -> LINE.
  - LINE: accepts a pixel when I_PIX_STB & I_DE. On de_fall -> WAIT_LINE; col=0; row+=1 (saturating); O_WR_BANK=(O_WR_BANK+1)%3.
  - In any state other than IDLE, vs_rise restarts the frame: row=0, col=0, O_WR_BANK=0. O_FRAME_DONE pulses that cycle, but only if row>0. Next state is WAIT_LINE.
  - vs_rise has priority over de_fall and over a pixel strobe in the same cycle. That pixel is dropped.
- Accepted pixel at (row r, col c), outputs registered, latency 1 cycle:
  - O_LB_WR_EN=1, O_LB_ADDR=c; col then increments.
  - O_WIN_VALID=1 iff r>=2 and c>=2, with O_CTR_ROW=r-1 and O_CTR_COL=c-1. Otherwise O_WIN_VALID=0.
  - O_CTR_ROW/O_CTR_COL hold their last values when O_WIN_VALID=0.
- Overflow: once col==MAX_WIDTH, further strobes on the line are dropped (no write, no window). col holds.
- I_PIX_STB with I_DE=0, or in IDLE: ignored.
- O_LB_WR_EN and O_WIN_VALID are single-cycle pulses, never high without a preceding accepted strobe.
- Reset asserted mid-line: immediate return to reset values. Nothing happens until the next vs_rise.

Optional Feature:
- Macro: EDGE_SCHED_ERR_EN.
- When defined:
  - Adds output O_ERR (1 bit, reset 0, sticky until reset or vs_rise).
  - The width of row 0 is latched at its de_fall.
  - O_ERR is set on the cycle after any later de_fall whose col differs from the latched width.
  - O_ERR is also set on any dropped overflow strobe.
- When undefined: no O_ERR port, no width register. Functional behaviour is otherwise identical.

Test Plan:
- Reset then 4 lines x 6 pixels, MAX_WIDTH=8, one strobe per 3 cycles:
  - O_LB_WR_EN pulses 24 times, with addresses 0..5 each line.
  - O_WR_BANK sequence 0,1,2,0.
  - O_WIN_VALID pulses 8 times, centers (1,1)..(1,4) and (2,1)..(2,4).
- Second vs_rise after the 4 lines -> O_FRAME_DONE single pulse; O_WR_BANK=0, row/col cleared; first strobe of the next line writes addr 0.
- 10 strobes on one line with MAX_WIDTH=8 -> only addresses 0..7 written, last 2 dropped.
  - With EDGE_SCHED_ERR_EN, O_ERR=1 after the first dropped strobe.
- vs_rise coincident with I_PIX_STB mid-line 3 -> strobe dropped, no O_WIN_VALID; row=0 and O_WR_BANK=0 the next cycle.
- I_RST low for 1 cycle during line 2 -> all outputs 0 immediately; strobes ignored until next vs_rise; then O_LB_ADDR restarts at 0.
- EDGE_SCHED_ERR_EN with line widths 6,6,5 -> O_ERR rises 1 cycle after the third de_fall and stays high until vs_rise.
